// File: rtl/memory_pkg.sv
// Shared types and constants for the wait-state memory and its storage array.
package memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_array.sv
// Synchronous single-port word storage; read data is registered one edge after addr.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wait_state_memory.sv
// EN/RW/MFC memory front end: request latch, wait-state counter, ROM/range
// decode and registered Data_out/MFC/ERR around a synchronous storage array.
module wait_state_memory
  import memory_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 256,
  parameter int ROM_WORDS = 8,
  parameter int LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic              RW,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] Data_in,
  output logic [DATA_W-1:0] Data_out,
  output logic              MFC,
  output logic              ERR
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              dropped_q, dropped_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              mfc_q, mfc_d;
  logic              err_q, err_d;

  logic              in_range_s;
  logic              in_rom_s;
  logic              legal_s;
  logic              complete_s;
  logic              we_s;
  logic              dropped_now_s;
  logic [IDX_W-1:0]  mem_idx_s;
  logic [DATA_W-1:0] rdata_s;

  // Range/ROM decode is done one bit wider so DEPTH = 2**ADDR_W still works.
  assign in_range_s = {1'b0, addr_q} < (ADDR_W + 1)'(DEPTH);
  assign in_rom_s   = {1'b0, addr_q} < (ADDR_W + 1)'(ROM_WORDS);
  assign legal_s    = in_range_s && !((rw_q == RW_WRITE) && in_rom_s);
  assign complete_s = (state_q == BUSY) && (cnt_q == '0);
  assign we_s       = complete_s && (rw_q == RW_WRITE) && in_range_s && !in_rom_s;

  // While idle the array looks at the live address so read data is ready by
  // the first possible completion edge (LATENCY = 1).
  assign mem_idx_s  = (state_q == IDLE) ? addr[IDX_W-1:0] : addr_q[IDX_W-1:0];

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we_s),
    .addr  (mem_idx_s),
    .wdata (wdata_q),
    .rdata (rdata_s)
  );

  // Next-state and output computation for the request FSM.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    rw_d          = rw_q;
    wdata_d       = wdata_q;
    dropped_d     = dropped_q;
    data_out_d    = data_out_q;
    mfc_d         = mfc_q;
    err_d         = err_q;
    dropped_now_s = dropped_q | ~EN;
    case (state_q)
      IDLE: begin
        if (EN) begin
          state_d   = BUSY;
          cnt_d     = CNT_W'(LATENCY - 1);
          addr_d    = addr;
          rw_d      = RW;
          wdata_d   = Data_in;
          dropped_d = 1'b0;
        end else begin
          state_d   = IDLE;
        end
      end
      BUSY: begin
        if (complete_s) begin
          if (rw_q == RW_READ) begin
            data_out_d = (in_range_s && !in_rom_s) ? rdata_s : '0;
          end else begin
            data_out_d = data_out_q;
          end
          // An abandoned request still completes but never handshakes.
          if (dropped_now_s) begin
            state_d = IDLE;
            mfc_d   = 1'b0;
            err_d   = 1'b0;
          end else begin
            state_d = DONE;
            mfc_d   = 1'b1;
            err_d   = !legal_s;
          end
        end else begin
          cnt_d     = cnt_q - CNT_W'(1);
          dropped_d = dropped_now_s;
        end
      end
      DONE: begin
        if (!EN) begin
          state_d = IDLE;
          mfc_d   = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
        mfc_d   = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  // State, request latches and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rw_q       <= RW_READ;
      wdata_q    <= '0;
      dropped_q  <= 1'b0;
      data_out_q <= '0;
      mfc_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      dropped_q  <= dropped_d;
      data_out_q <= data_out_d;
      mfc_q      <= mfc_d;
      err_q      <= err_d;
    end
  end

  assign Data_out = data_out_q;
  assign MFC      = mfc_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_wait_state_memory.sv
// Bench for wait_state_memory: a LATENCY=2 and a LATENCY=5 instance driven
// from a vector table plus hand sequences, checked through a scoreboard queue.
module tb_wait_state_memory;

  logic        clk;
  logic        rst_n;
  logic        en0, en5;
  logic        RW;
  logic [15:0] addr;
  logic [15:0] Data_in;
  logic [15:0] dout0, dout5;
  logic        mfc0, mfc5, err0, err5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_d;
    logic        exp_e;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        e;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  wait_state_memory #(.LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .EN(en0), .RW(RW), .addr(addr),
    .Data_in(Data_in), .Data_out(dout0), .MFC(mfc0), .ERR(err0)
  );

  wait_state_memory #(.LATENCY(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .EN(en5), .RW(RW), .addr(addr),
    .Data_in(Data_in), .Data_out(dout5), .MFC(mfc5), .ERR(err5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_en(input bit s5, input logic v);
    if (s5) en5 = v;
    else    en0 = v;
  endtask

  function automatic logic cur_mfc(input bit s5);
    return s5 ? mfc5 : mfc0;
  endfunction

  // One full handshake; inputs are scrambled right after acceptance.
  task automatic txn(input bit s5, input logic rw, input logic [15:0] a,
                     input logic [15:0] d, input int hold,
                     input logic [15:0] exp_d, input logic exp_e);
    int   cyc;
    logic got;
    exp_t e;
    sb.push_back('{d: exp_d, e: exp_e});
    @(negedge clk);
    RW = rw; addr = a; Data_in = d;
    set_en(s5, 1'b1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        RW = ~rw; addr = a + 16'd1; Data_in = ~d;
      end
      got = cur_mfc(s5);
    end
    check("latency", 32'(cyc - 1), s5 ? 32'd5 : 32'd2);
    e = sb.pop_front();
    check("data_out", {16'h0000, s5 ? dout5 : dout0}, {16'h0000, e.d});
    check("err", {31'd0, s5 ? err5 : err0}, {31'd0, e.e});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("mfc_hold", {31'd0, cur_mfc(s5)}, 32'd1);
    end
    set_en(s5, 1'b0);
    @(negedge clk);
    check("mfc_drop", {31'd0, cur_mfc(s5)}, 32'd0);
    check("err_drop", {31'd0, s5 ? err5 : err0}, 32'd0);
  endtask

  initial begin
    logic seen;

    vecs.push_back('{1'b0, 16'h0020, 16'hBEEF, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 16'h0020, 16'h0000, 16'hBEEF, 1'b0});
    vecs.push_back('{1'b0, 16'h0003, 16'h1234, 16'hBEEF, 1'b1});
    vecs.push_back('{1'b1, 16'h0003, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 16'h0100, 16'h0000, 16'h0000, 1'b1});
    vecs.push_back('{1'b0, 16'hFFFF, 16'h5555, 16'h0000, 1'b1});
    vecs.push_back('{1'b0, 16'h00FF, 16'hCAFE, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 16'h00FF, 16'h0000, 16'hCAFE, 1'b0});
    vecs.push_back('{1'b1, 16'h0007, 16'h0000, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 16'h0008, 16'h7777, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 16'h0008, 16'h0000, 16'h7777, 1'b0});
    vecs.push_back('{1'b1, 16'h0020, 16'h0000, 16'hBEEF, 1'b0});
    vecs.push_back('{1'b1, 16'h1020, 16'h0000, 16'h0000, 1'b1});
    vecs.push_back('{1'b1, 16'h00FF, 16'h0000, 16'hCAFE, 1'b0});
    vecs.push_back('{1'b0, 16'h0040, 16'h1111, 16'hCAFE, 1'b0});

    rst_n = 1'b0; en0 = 1'b0; en5 = 1'b0; RW = 1'b1; addr = 16'h0000; Data_in = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_dout", {16'h0000, dout0}, 32'h0);
    check("rst_mfc",  {31'd0, mfc0}, 32'd0);
    check("rst_err",  {31'd0, err0}, 32'd0);
    check("rst_dout5", {16'h0000, dout5}, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      txn(1'b0, vecs[i].rw, vecs[i].a, vecs[i].d, 0, vecs[i].exp_d, vecs[i].exp_e);
    end

    // EN held long after MFC: one transaction only, MFC stays up.
    txn(1'b0, 1'b0, 16'h0030, 16'hABCD, 10, 16'hCAFE, 1'b0);
    txn(1'b0, 1'b1, 16'h0030, 16'h0000, 0, 16'hABCD, 1'b0);

    // Reset in the middle of a write: outputs clear at once, nothing commits.
    @(negedge clk);
    RW = 1'b0; addr = 16'h0040; Data_in = 16'hDEAD; en0 = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout", {16'h0000, dout0}, 32'h0);
    check("async_rst_mfc",  {31'd0, mfc0}, 32'd0);
    check("async_rst_err",  {31'd0, err0}, 32'd0);
    en0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(1'b0, 1'b1, 16'h0040, 16'h0000, 0, 16'h1111, 1'b0);

    // LATENCY=5: request abandoned in BUSY still commits, no MFC.
    @(negedge clk);
    RW = 1'b0; addr = 16'h0009; Data_in = 16'h00AA; en5 = 1'b1;
    @(negedge clk);
    en5 = 1'b0; addr = 16'h0000; Data_in = 16'h0000;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (mfc5) seen = 1'b1;
    end
    check("drop_no_mfc", {31'd0, seen}, 32'd0);
    txn(1'b1, 1'b1, 16'h0009, 16'h0000, 0, 16'h00AA, 1'b0);
    txn(1'b1, 1'b0, 16'h0002, 16'h4321, 0, 16'h00AA, 1'b1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
